// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - N-digit 7-segment scan controller, double-buffered; option LEADING_ZERO_BLANK_EN
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD_CYC   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [7:0]              seg_in,
   output logic [3:0]              nibble,
   output logic [7:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done,
   output logic                    load_ack
);

   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CMAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_ON    = 2'd1;
   localparam logic [1:0] S_GUARD = 2'd2;

   localparam logic [CW-1:0]         ON_LAST    = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYC - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

   logic [1:0]              state, nxt_state;
   logic [IW-1:0]           idx, nxt_idx;
   logic [CW-1:0]           cnt, nxt_cnt;
   logic [4*NUM_DIGITS-1:0] act_val, nxt_act_val, pend_val;
   logic [NUM_DIGITS-1:0]   act_dp, nxt_act_dp, pend_dp;
   logic                    pend_flag;
   logic                    slot_dp_only;
   logic                    wrap;
   logic [3:0]              nxt_nib;
   logic                    nxt_dp, nxt_blank, nxt_show;
`ifdef LEADING_ZERO_BLANK_EN
   logic                    upper_zero;
`endif

   // Frame boundary: last guard cycle of the last digit while scanning
   assign wrap       = en && (state == S_GUARD) && (cnt == GUARD_LAST) && (idx == IDX_LAST);
   assign frame_done = wrap;
   assign load_ack   = wrap && (pend_flag || load);

   // Scan sequencer next state; en low forces OFF and clears position
   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_cnt   = cnt;
      if (!en) begin
         nxt_state = S_OFF;
         nxt_idx   = '0;
         nxt_cnt   = '0;
      end else begin
         case (state)
            S_OFF: begin
               nxt_state = S_ON;
               nxt_idx   = '0;
               nxt_cnt   = '0;
            end
            S_ON: begin
               if (cnt == ON_LAST) begin
                  nxt_state = S_GUARD;
                  nxt_cnt   = '0;
               end else begin
                  nxt_cnt = cnt + 1'b1;
               end
            end
            S_GUARD: begin
               if (cnt == GUARD_LAST) begin
                  nxt_state = S_ON;
                  nxt_cnt   = '0;
                  nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
               end else begin
                  nxt_cnt = cnt + 1'b1;
               end
            end
            default: begin
               nxt_state = S_OFF;
               nxt_idx   = '0;
               nxt_cnt   = '0;
            end
         endcase
      end
   end

   // Active buffer commits only at the frame boundary; a same-cycle load bypasses pending
   always_comb begin
      nxt_act_val = act_val;
      nxt_act_dp  = act_dp;
      if (wrap) begin
         if (load) begin
            nxt_act_val = value;
            nxt_act_dp  = dp_mask;
         end else if (pend_flag) begin
            nxt_act_val = pend_val;
            nxt_act_dp  = pend_dp;
         end
      end
   end

   // Digit selection for the upcoming slot, including optional leading-zero blanking
   always_comb begin
      nxt_nib   = nxt_act_val[{nxt_idx, 2'b00} +: 4];
      nxt_dp    = nxt_act_dp[nxt_idx];
      nxt_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (digit_en[i] && (nxt_act_val[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
         if (IW'(i) == nxt_idx) nxt_blank = upper_zero && (i != 0);
      end
`endif
      nxt_show = (nxt_state == S_ON) && digit_en[nxt_idx] && (!nxt_blank || nxt_dp);
   end

   // Sequencer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_OFF;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= nxt_state;
         idx   <= nxt_idx;
         cnt   <= nxt_cnt;
      end
   end

   // Double buffer: pending captures every load, active takes it at frame end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_val   <= '0;
         act_dp    <= '0;
         pend_val  <= '0;
         pend_dp   <= '0;
         pend_flag <= 1'b0;
      end else begin
         act_val <= nxt_act_val;
         act_dp  <= nxt_act_dp;
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_mask;
         end
         if (wrap)      pend_flag <= 1'b0;
         else if (load) pend_flag <= 1'b1;
      end
   end

   // Anode and nibble registered together so they switch on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n         <= '1;
         nibble       <= 4'h0;
         slot_dp_only <= 1'b0;
      end else begin
         an_n         <= '1;
         slot_dp_only <= 1'b0;
         if (nxt_state == S_ON) begin
            nibble       <= nxt_nib;
            slot_dp_only <= nxt_blank;
            if (nxt_show) an_n <= ~(ONE_HOT0 << nxt_idx);
         end
      end
   end

   // Segment gating: decoder pattern plus DP only while a digit is actually lit
   always_comb begin
      seg_n = 8'hFF;
      if ((state == S_ON) && (an_n != '1))
         seg_n = slot_dp_only ? 8'hFE : {seg_in[7:1], ~act_dp[idx]};
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, en, load;
   logic [31:0] value;
   logic [7:0]  dp_mask, digit_en, seg_in;
   logic [3:0]  nibble;
   logic [7:0]  seg_n, an_n;
   logic        frame_done, load_ack;

   int pass_cnt = 0;
   int total    = 0;

   typedef struct {
      logic [7:0] an;
      logic [3:0] nib;
      logic [7:0] seg;
      int         len;
   } slot_t;

   slot_t slot_q[$];
   int    ack_q[$];
   logic  mon_on = 1'b0;

   seg7_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4), .GUARD_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
      .dp_mask(dp_mask), .digit_en(digit_en), .seg_in(seg_in),
      .nibble(nibble), .seg_n(seg_n), .an_n(an_n),
      .frame_done(frame_done), .load_ack(load_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      case (n)
         4'h0: dec7 = 7'b0000001;  4'h1: dec7 = 7'b1001111;
         4'h2: dec7 = 7'b0010010;  4'h3: dec7 = 7'b0000110;
         4'h4: dec7 = 7'b1001100;  4'h5: dec7 = 7'b0100100;
         4'h6: dec7 = 7'b0100000;  4'h7: dec7 = 7'b0001111;
         4'h8: dec7 = 7'b0000000;  4'h9: dec7 = 7'b0000100;
         4'hA: dec7 = 7'b0001000;  4'hB: dec7 = 7'b1100000;
         4'hC: dec7 = 7'b0110001;  4'hD: dec7 = 7'b1000010;
         4'hE: dec7 = 7'b0110000;  default: dec7 = 7'b0111000;
      endcase
   endfunction

   // External decoder; its DP bit is driven low so a DUT that passes it through is caught
   assign seg_in = {dec7(nibble), 1'b0};

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_frame(output int n);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         step();
         n++;
         if (frame_done) return;
      end
      total++;
      $display("FAIL frame_wait: no frame_done within 200 cycles");
      n = -1;
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input bit expect_ack);
      value   = v;
      dp_mask = dp;
      load    = 1'b1;
      if (expect_ack) ack_q.push_back(1);
   endtask

   // Expected lit slots for one frame, in scan order
   task automatic push_frame(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] den);
      slot_t s [8];
      bit    have [8];
      logic  seen, blank;
      logic [3:0] nb;
      seen = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         nb = v[4*i +: 4];
         if (den[i] && nb != 4'h0) seen = 1'b1;
         blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         blank = (i > 0) && !seen;
`endif
         have[i]  = den[i] && (!blank || dp[i]);
         s[i].an  = ~(8'h01 << i);
         s[i].nib = nb;
         s[i].seg = blank ? 8'hFE : {dec7(nb), ~dp[i]};
         s[i].len = 4;
      end
      for (int i = 0; i < 8; i++) if (have[i]) slot_q.push_back(s[i]);
   endtask

   // Monitor: slot captures and load_ack/frame_done pulses against the queues
   initial begin
      slot_t cur, e;
      bit in_slot = 0;
      bit exp_ack;
      forever begin
         @(negedge clk);
         if (frame_done || load_ack) begin
            exp_ack = (ack_q.size() > 0);
            total++;
            if ((load_ack == exp_ack) && (!load_ack || frame_done)) pass_cnt++;
            else $display("FAIL load_ack: got ack=%0b frame_done=%0b expected ack=%0b", load_ack, frame_done, exp_ack);
            if (exp_ack) void'(ack_q.pop_front());
         end
         if (an_n != 8'hFF) begin
            if (in_slot) cur.len++;
            else if (mon_on) begin
               in_slot = 1; cur.an = an_n; cur.nib = nibble; cur.seg = seg_n; cur.len = 1;
            end
         end else if (in_slot) begin
            in_slot = 0;
            total++;
            if (slot_q.size() == 0) begin
               $display("FAIL slot: unexpected an=%h nib=%h seg=%h len=%0d", cur.an, cur.nib, cur.seg, cur.len);
            end else begin
               e = slot_q.pop_front();
               if (cur.an == e.an && cur.nib == e.nib && cur.seg == e.seg && cur.len == e.len) pass_cnt++;
               else $display("FAIL slot: got an=%h nib=%h seg=%h len=%0d expected an=%h nib=%h seg=%h len=%0d",
                             cur.an, cur.nib, cur.seg, cur.len, e.an, e.nib, e.seg, e.len);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; en = 1'b0; load = 1'b0;
      value = '0; dp_mask = '0; digit_en = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_an_n", an_n, 8'hFF);
      check("rst_seg_n", seg_n, 8'hFF);
      check("rst_nibble", nibble, 4'h0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_load_ack", load_ack, 1'b0);
      rst_n = 1'b1;
      step();

      // 1: first load commits at cycle 40, then full frame of 89ABCDEF
      en = 1'b1;
      do_load(32'h89ABCDEF, 8'h00, 1);
      wait_frame(n);
      check("t1_first_frame_len", n, 40);
      mon_on = 1'b1;
      push_frame(32'h89ABCDEF, 8'h00, 8'hFF);
      wait_frame(n);
      check("t1_frame_len", n, 40);
      mon_on = 1'b0;

      // 2: two loads in one frame, last wins, one ack
      repeat (5) step();
      do_load(32'h00000001, 8'h00, 0);
      repeat (10) step();
      do_load(32'h00000002, 8'h00, 1);
      wait_frame(n);
      mon_on = 1'b1;
      push_frame(32'h00000002, 8'h00, 8'hFF);
      wait_frame(n);
      // load on the commit cycle goes straight to active
      do_load(32'h76543210, 8'h00, 1);
      push_frame(32'h76543210, 8'h00, 8'hFF);
      wait_frame(n);
      check("t2_frame_len", n, 40);
      mon_on = 1'b0;

      // 3: digits 4-7 disabled, DP on digit 0
      repeat (3) step();
      do_load(32'h12345678, 8'h01, 1);
      wait_frame(n);
      digit_en = 8'h0F;
      mon_on   = 1'b1;
      push_frame(32'h12345678, 8'h01, 8'h0F);
      wait_frame(n);
      check("t3_frame_len", n, 40);
      mon_on   = 1'b0;
      digit_en = 8'hFF;

      // 4: en dropped mid slot 3, load held while dark, restart from digit 0
      repeat (17) step();
      en = 1'b0;
      step();
      check("t4_an_dark", an_n, 8'hFF);
      check("t4_seg_dark", seg_n, 8'hFF);
      check("t4_nibble_hold", nibble, 4'h5);
      do_load(32'hFEDCBA98, 8'h00, 1);
      repeat (5) step();
      check("t4_still_dark", an_n, 8'hFF);
      en     = 1'b1;
      mon_on = 1'b1;
      push_frame(32'h12345678, 8'h01, 8'hFF);
      wait_frame(n);
      check("t4_restart_len", n, 40);
      push_frame(32'hFEDCBA98, 8'h00, 8'hFF);
      wait_frame(n);
      mon_on = 1'b0;

      // 5: reset mid-frame with a pending load
      repeat (7) step();
      do_load(32'h55555555, 8'h00, 0);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("t5_an_n", an_n, 8'hFF);
      check("t5_seg_n", seg_n, 8'hFF);
      check("t5_nibble", nibble, 4'h0);
      check("t5_frame_done", frame_done, 1'b0);
      check("t5_load_ack", load_ack, 1'b0);
      repeat (2) step();
      rst_n  = 1'b1;
      mon_on = 1'b1;
      push_frame(32'h00000000, 8'h00, 8'hFF);
      wait_frame(n);
      check("t5_frame_len", n, 40);
      push_frame(32'h00000000, 8'h00, 8'hFF);
      wait_frame(n);
      mon_on = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
      // 6: leading-zero blanking
      step();
      do_load(32'h00000120, 8'h00, 1);
      wait_frame(n);
      mon_on = 1'b1;
      push_frame(32'h00000120, 8'h00, 8'hFF);
      wait_frame(n);
      mon_on = 1'b0;
      step();
      do_load(32'h00000000, 8'h10, 1);
      wait_frame(n);
      mon_on = 1'b1;
      push_frame(32'h00000000, 8'h10, 8'hFF);
      wait_frame(n);
      mon_on = 1'b0;
`endif

      repeat (3) step();
      check("end_slot_q_empty", slot_q.size(), 0);
      check("end_ack_q_empty", ack_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
